// File: rtl/regfile_mp.sv
// Multi-port integer register file: async reads with optional write bypass, prioritised sync
// writes, per-register busy scoreboard and a post-reset zero sweep before the file is usable.

module regfile_mp_rd #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = 5
) (
  input  logic                       run,
  input  logic [AW-1:0]              addr,
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy,
  input  logic [NWR-1:0]             wr_ok,
  input  logic [NWR*AW-1:0]          wr_addr,
  input  logic [NWR*XLEN-1:0]        wr_data,
  output logic [XLEN-1:0]            data,
  output logic                       pend
);
  logic            valid;
  logic            hit;
  logic [XLEN-1:0] hdata;

  // later ports overwrite earlier matches, so the highest index wins
  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    for (int i = 0; i < NWR; i++) begin
      if (BYPASS != 0 && wr_ok[i] && wr_addr[i*AW +: AW] == addr) begin
        hit   = 1'b1;
        hdata = wr_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    valid = run && (addr != '0) && (int'(addr) < NREGS);
    data  = '0;
    pend  = 1'b0;
    if (valid) begin
      data = hit ? hdata : regs[addr];
      pend = busy[addr] & ~hit;
    end
  end
endmodule

module regfile_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*AW-1:0]      wr_addr,
  input  logic [NWR*XLEN-1:0]    wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   ready
);
  typedef enum logic {INIT, RUN} state_t;

  state_t                     state;
  logic [AW-1:0]              idx;
  logic [XLEN-1:0]            regs_q [1:NREGS-1];
  logic [NREGS-1:1]           busy_q;
  logic [NREGS-1:0][XLEN-1:0] regs_v;
  logic [NREGS-1:0]           busy_v;
  logic [NWR-1:0]             wr_ok;
  logic                       iss_ok;
  logic                       run;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  assign run = (state == RUN);

  always_comb begin
    for (int i = 0; i < NWR; i++)
      wr_ok[i] = run && wr_en[i] && in_range(wr_addr[i*AW +: AW]);
    iss_ok = run && iss_en && in_range(iss_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= INIT;
      idx    <= AW'(1);
      busy_q <= '0;
      ready  <= 1'b0;
    end else if (state == INIT) begin
      idx <= idx + 1'b1;
      if (idx == AW'(NREGS-1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_ok[i]) busy_q[wr_addr[i*AW +: AW]] <= 1'b0;
      // issue lands after writeback clears so a same-cycle reissue stays busy
      if (iss_ok) busy_q[iss_addr] <= 1'b1;
    end
  end

  // storage has no reset; the INIT sweep zeroes it one register per cycle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        regs_q[idx] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++)
          if (wr_ok[i]) regs_q[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    regs_v = '0;
    busy_v = '0;
    for (int r = 1; r < NREGS; r++) begin
      regs_v[r] = regs_q[r];
      busy_v[r] = busy_q[r];
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_mp_rd #(
      .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
    ) u_rd (
      .run     (run),
      .addr    (rd_addr[j*AW +: AW]),
      .regs    (regs_v),
      .busy    (busy_v),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[j*XLEN +: XLEN]),
      .pend    (rd_busy[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench: two register files (32 regs with bypass, 20 regs without) driven by shared stimulus
// and compared every cycle against an array-based model, plus directed literal expectations.

module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NRD*XLEN-1:0] rd_data0, rd_data1;
  logic [NRD-1:0]      rd_busy0, rd_busy1;
  logic                ready0, ready1;

  int checks = 0;
  int failures = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .ready(ready0));

  regfile_mp #(.XLEN(XLEN), .NREGS(20), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .ready(ready1));

  // model: architectural contents, busy flags, readiness and sweep progress per instance
  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  bit          rdy [2];
  int          cnt [2];

  function automatic int nr(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rdy[k] = 1'b0;
        cnt[k] = 0;
        for (int r = 0; r < 32; r++) bsy[k][r] = 1'b0;
      end else if (!rdy[k]) begin
        cnt[k]++;
        mem[k][cnt[k]] = '0;
        if (cnt[k] == nr(k) - 1) rdy[k] = 1'b1;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          int a;
          a = int'(wr_addr[i*AW +: AW]);
          if (wr_en[i] && a != 0 && a < nr(k)) begin
            mem[k][a] = wr_data[i*XLEN +: XLEN];
            bsy[k][a] = 1'b0;
          end
        end
        if (iss_en && iss_addr != 0 && int'(iss_addr) < nr(k)) bsy[k][iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic mdl_rd(input int k, input int a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (rdy[k] && a != 0 && a < nr(k)) begin
      d = mem[k][a];
      b = bsy[k][a];
      if (k == 0)
        for (int i = 0; i < NWR; i++)
          if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == a) begin
            d = wr_data[i*XLEN +: XLEN];
            b = 1'b0;
          end
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      logic [31:0] ed;
      logic        eb;
      chk("ready0", {31'd0, ready0}, {31'd0, rdy[0]});
      chk("ready1", {31'd0, ready1}, {31'd0, rdy[1]});
      for (int j = 0; j < NRD; j++) begin
        mdl_rd(0, int'(rd_addr[j*AW +: AW]), ed, eb);
        chk("m_rd_data0", rd_data0[j*XLEN +: XLEN], ed);
        chk("m_rd_busy0", {31'd0, rd_busy0[j]}, {31'd0, eb});
        mdl_rd(1, int'(rd_addr[j*AW +: AW]), ed, eb);
        chk("m_rd_data1", rd_data1[j*XLEN +: XLEN], ed);
        chk("m_rd_busy1", {31'd0, rd_busy1[j]}, {31'd0, eb});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    repeat (3) tick();
    go = 1'b1;
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    rd(0, 1); #1;
    chk("rst_rd0", rd_data0[31:0], 32'd0);

    // sweep timing: 31 edges for 32 regs, 19 edges for 20 regs
    rst_n = 1'b1;
    repeat (30) tick();
    chk("ready0_30", {31'd0, ready0}, 32'd0);
    chk("ready1_30", {31'd0, ready1}, 32'd1);
    tick();
    chk("ready0_31", {31'd0, ready0}, 32'd1);
    for (int a = 1; a < 32; a++) begin
      rd(0, a); rd(1, a); #1;
      chk("sweep_rd0", rd_data0[31:0], 32'd0);
      chk("sweep_rd1", rd_data1[63:32], 32'd0);
    end

    wr(0, 5, 32'hAAAA_0000); wr(1, 5, 32'h5555_1111);
    tick(); idle(); rd(0, 5); #1;
    chk("prio_x5_0", rd_data0[31:0], 32'h5555_1111);
    chk("prio_x5_1", rd_data1[31:0], 32'h5555_1111);

    wr(0, 7, 32'hDEAD_BEEF); rd(0, 7); #1;
    chk("byp_x7_0", rd_data0[31:0], 32'hDEAD_BEEF);
    chk("nobyp_x7_1", rd_data1[31:0], 32'h0);
    tick(); idle(); #1;
    chk("after_x7_1", rd_data1[31:0], 32'hDEAD_BEEF);

    wr(0, 0, 32'hFFFF_FFFF); iss_en = 1'b1; iss_addr = '0;
    tick(); idle(); rd(0, 0); #1;
    chk("x0_data", rd_data0[31:0], 32'h0);
    chk("x0_busy", {31'd0, rd_busy0[0]}, 32'd0);

    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle(); rd(1, 9); #1;
    chk("iss9_busy0", {31'd0, rd_busy0[1]}, 32'd1);
    chk("iss9_busy1", {31'd0, rd_busy1[1]}, 32'd1);
    wr(0, 9, 32'h99); iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle(); #1;
    chk("reiss9_busy0", {31'd0, rd_busy0[1]}, 32'd1);
    wr(0, 9, 32'h9A); #1;
    chk("wb9_bypass_busy0", {31'd0, rd_busy0[1]}, 32'd0);
    chk("wb9_nobyp_busy1", {31'd0, rd_busy1[1]}, 32'd1);
    tick(); idle(); #1;
    chk("wb9_busy0", {31'd0, rd_busy0[1]}, 32'd0);
    chk("wb9_busy1", {31'd0, rd_busy1[1]}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      wr_en    = NWR'($urandom);
      wr_addr  = (NWR*AW)'($urandom);
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom);
      rd_addr  = (NRD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr[AW-1:0];
      tick();
    end

    rst_n = 1'b1; idle();
    repeat (35) tick();
    wr(0, 3, 32'h12);
    tick(); idle(); rd(0, 3); #1;
    chk("x3_written", rd_data0[31:0], 32'h12);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (10) tick();
    chk("midsweep_ready0", {31'd0, ready0}, 32'd0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (31) tick();
    chk("restart_ready0", {31'd0, ready0}, 32'd1);
    chk("restart_x3", rd_data0[31:0], 32'h0);
    tick();

    go = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
